// File: rtl/shaper_tdm_pkg.sv
// Shared types and width helpers for the shaper TDM scheduler.
// Optional section saturation is enabled by defining SHAPER_TDM_SAT_EN.
package shaper_tdm_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam logic [1:0] COEF_B0 = 2'd0;
   localparam logic [1:0] COEF_B1 = 2'd1;
   localparam logic [1:0] COEF_A1 = 2'd2;
   localparam logic [1:0] COEF_A2 = 2'd3;

   // Width of section outputs, the accumulator and the bank output.
   function automatic int sum_width(input int bits_in);
      return bits_in + 17;
   endfunction

   // Full-precision width of the four-term MAC sum.
   function automatic int mac_width(input int bits_in, input int coef_w);
      return sum_width(bits_in) + coef_w + 2;
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/shaper_tdm_scheduler_mac.sv
// Shared combinational section MAC: s = b0*x + b1*x_prev - a1*y1 - a2*y2, then >>> G.
// With SHAPER_TDM_SAT_EN the shifted result clips to SW bits and raises clip; otherwise it wraps.
module iir_sec_mac
   import shaper_tdm_pkg::*;
#(
   parameter int BITS_IN     = 34,
   parameter int COEF_W      = 16,
   parameter int G_SAIDA_LOG = 10
) (
   input  logic signed [BITS_IN-1:0]            x,
   input  logic signed [BITS_IN-1:0]            x_prev,
   input  logic signed [sum_width(BITS_IN)-1:0] y1,
   input  logic signed [sum_width(BITS_IN)-1:0] y2,
   input  logic signed [COEF_W-1:0]             b0,
   input  logic signed [COEF_W-1:0]             b1,
   input  logic signed [COEF_W-1:0]             a1,
   input  logic signed [COEF_W-1:0]             a2,
   output logic signed [sum_width(BITS_IN)-1:0] y,
   output logic                                 clip
);

   localparam int SW = sum_width(BITS_IN);
   localparam int MW = mac_width(BITS_IN, COEF_W);

   logic signed [MW-1:0] s;

   always_comb begin
      s = MW'(b0) * MW'(x) + MW'(b1) * MW'(x_prev)
        - MW'(a1) * MW'(y1) - MW'(a2) * MW'(y2);
   end

`ifdef SHAPER_TDM_SAT_EN
   logic signed [MW-1:0] sh;
   logic [MW-SW:0]       hi;
   logic                 ovf;

   assign sh  = s >>> G_SAIDA_LOG;
   assign hi  = sh[MW-1:SW-1];
   // In range only when every bit from the SW sign position up is a sign copy.
   assign ovf = !((&hi) || (~|hi));

   always_comb begin
      y    = sh[SW-1:0];
      clip = ovf;
      if (ovf) begin
         y = sh[MW-1] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
      end
   end
`else
   assign y    = SW'(s >>> G_SAIDA_LOG);
   assign clip = 1'b0;
`endif

endmodule

// File: rtl/shaper_tdm_scheduler.sv
// TDM scheduler: one shared MAC sweeps all IIR sections per accepted sample and sums them.
// Shadow/active coefficient banks with atomic commit; saturation via SHAPER_TDM_SAT_EN.
module shaper_tdm_scheduler
   import shaper_tdm_pkg::*;
#(
   parameter int BITS_IN     = 34,
   parameter int NUM_SEC     = 7,
   parameter int COEF_W      = 16,
   parameter int G_SAIDA_LOG = 10
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 in_valid,
   input  logic signed [BITS_IN-1:0]            in,
   output logic                                 in_ready,
   input  logic                                 cfg_we,
   input  logic [idx_width(NUM_SEC)-1:0]        cfg_addr,
   input  logic [1:0]                           cfg_sel,
   input  logic signed [COEF_W-1:0]             cfg_data,
   input  logic                                 cfg_commit,
   output logic                                 out_valid,
   output logic signed [sum_width(BITS_IN)-1:0] out,
   output logic                                 busy,
   output logic                                 sat_flag
);

   localparam int SW = sum_width(BITS_IN);
   localparam int AW = idx_width(NUM_SEC);
   localparam logic [AW-1:0] LAST_SEC  = AW'(NUM_SEC - 1);
   localparam logic [AW:0]   NUM_SEC_W = (AW+1)'(NUM_SEC);

   state_t state_q, state_d;

   logic [AW-1:0]             sec_q;
   logic signed [BITS_IN-1:0] x_q, x_prev_q;
   logic signed [SW-1:0]      acc_q, out_q, acc_sum;
   logic signed [SW-1:0]      y1_q [NUM_SEC];
   logic signed [SW-1:0]      y2_q [NUM_SEC];
   logic signed [COEF_W-1:0]  shadow_q   [NUM_SEC][4];
   logic signed [COEF_W-1:0]  shadow_nxt [NUM_SEC][4];
   logic signed [COEF_W-1:0]  active_q   [NUM_SEC][4];
   logic                      commit_pending_q, sat_q;
   logic                      accept, commit_now, cfg_hit, last_sec;
   logic signed [SW-1:0]      sec_y;
   logic                      sec_clip;

   assign in_ready   = (state_q == IDLE) & ~reset;
   assign busy       = (state_q != IDLE);
   assign out_valid  = (state_q == DONE) & ~reset;
   assign out        = out_q;
   assign sat_flag   = sat_q;

   assign accept     = in_valid & in_ready;
   assign commit_now = (state_q == IDLE) & (commit_pending_q | cfg_commit);
   assign cfg_hit    = cfg_we & ({1'b0, cfg_addr} < NUM_SEC_W);
   assign last_sec   = (sec_q == LAST_SEC);
   assign acc_sum    = acc_q + sec_y;

   // Same-cycle writes are folded in here so a coincident commit copies them too.
   always_comb begin
      shadow_nxt = shadow_q;
      if (cfg_hit) begin
         shadow_nxt[cfg_addr][cfg_sel] = cfg_data;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (last_sec) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   iir_sec_mac #(
      .BITS_IN     (BITS_IN),
      .COEF_W      (COEF_W),
      .G_SAIDA_LOG (G_SAIDA_LOG)
   ) u_mac (
      .x      (x_q),
      .x_prev (x_prev_q),
      .y1     (y1_q[sec_q]),
      .y2     (y2_q[sec_q]),
      .b0     (active_q[sec_q][COEF_B0]),
      .b1     (active_q[sec_q][COEF_B1]),
      .a1     (active_q[sec_q][COEF_A1]),
      .a2     (active_q[sec_q][COEF_A2]),
      .y      (sec_y),
      .clip   (sec_clip)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q          <= IDLE;
         sec_q            <= '0;
         x_q              <= '0;
         x_prev_q         <= '0;
         acc_q            <= '0;
         out_q            <= '0;
         commit_pending_q <= 1'b0;
         sat_q            <= 1'b0;
         y1_q             <= '{default: '0};
         y2_q             <= '{default: '0};
         shadow_q         <= '{default: '0};
         active_q         <= '{default: '0};
      end else begin
         state_q          <= state_d;
         shadow_q         <= shadow_nxt;
         commit_pending_q <= commit_now ? 1'b0 : (commit_pending_q | cfg_commit);
         if (commit_now) begin
            active_q <= shadow_nxt;
         end
         case (state_q)
            IDLE: begin
               if (accept) begin
                  x_q   <= in;
                  sec_q <= '0;
               end
            end
            RUN: begin
               y1_q[sec_q] <= sec_y;
               y2_q[sec_q] <= y1_q[sec_q];
               acc_q       <= acc_sum;
               sat_q       <= sat_q | sec_clip;
               if (last_sec) begin
                  sec_q <= '0;
                  // Bank result is registered here so it is already on out during the DONE strobe.
                  out_q <= acc_sum;
               end else begin
                  sec_q <= sec_q + 1'b1;
               end
            end
            DONE: begin
               acc_q    <= '0;
               x_prev_q <= x_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shaper_tdm_scheduler.sv
// Scoreboard bench for shaper_tdm_scheduler: default instance plus a BITS_IN=8 instance for clipping/wrap.
module tb_shaper_tdm_scheduler;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic               reset, in_valid, cfg_we, cfg_commit;
   logic signed [33:0] in;
   logic [2:0]         cfg_addr;
   logic [1:0]         cfg_sel;
   logic signed [15:0] cfg_data;
   logic               in_ready, out_valid, busy, sat_flag;
   logic signed [50:0] out;

   logic               reset8, in_valid8, cfg_we8, cfg_commit8;
   logic signed [7:0]  in8;
   logic [2:0]         cfg_addr8;
   logic [1:0]         cfg_sel8;
   logic signed [15:0] cfg_data8;
   logic               in_ready8, out_valid8, busy8, sat_flag8;
   logic signed [24:0] out8;

   shaper_tdm_scheduler #(
      .BITS_IN(34), .NUM_SEC(7), .COEF_W(16), .G_SAIDA_LOG(10)
   ) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in(in), .in_ready(in_ready),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
      .cfg_commit(cfg_commit), .out_valid(out_valid), .out(out), .busy(busy),
      .sat_flag(sat_flag)
   );

   shaper_tdm_scheduler #(
      .BITS_IN(8), .NUM_SEC(7), .COEF_W(16), .G_SAIDA_LOG(10)
   ) dut8 (
      .clock(clock), .reset(reset8), .in_valid(in_valid8), .in(in8), .in_ready(in_ready8),
      .cfg_we(cfg_we8), .cfg_addr(cfg_addr8), .cfg_sel(cfg_sel8), .cfg_data(cfg_data8),
      .cfg_commit(cfg_commit8), .out_valid(out_valid8), .out(out8), .busy(busy8),
      .sat_flag(sat_flag8)
   );

   typedef struct {
      logic signed [50:0] v;
      int                 c;
   } exp_t;

   exp_t               q[$];
   logic signed [24:0] q8[$];
   int                 checks = 0;
   int                 errors = 0;
   int                 cyc = 0;
   bit                 done8 = 1'b0;
   exp_t               e;
   logic signed [24:0] e8;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (out_valid) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out_valid: out=%0d at cycle %0d, required no strobe", out, cyc);
         end else begin
            e = q.pop_front();
            if (out !== e.v || cyc != e.c) begin
               errors++;
               $display("FAIL out: got %0d at cycle %0d, required %0d at cycle %0d", out, cyc, e.v, e.c);
            end
         end
      end
   end

   always @(negedge clock) begin
      if (out_valid8) begin
         checks++;
         if (q8.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out_valid8: out8=%0d, required no strobe", out8);
         end else begin
            e8 = q8.pop_front();
            if (out8 !== e8) begin
               errors++;
               $display("FAIL out8: got %0d, required %0d", out8, e8);
            end
         end
      end
   end

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0;
      @(negedge clock);
      check("in_ready_in_reset", longint'(in_ready), 0);
      check("busy_reset", longint'(busy), 0);
      check("out_valid_reset", longint'(out_valid), 0);
      check("out_reset", longint'(out), 0);
      check("sat_flag_reset", longint'(sat_flag), 0);
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic cfg_write(input int addr, input int sel, input int data, input bit commit);
      cfg_we = 1'b1; cfg_addr = 3'(addr); cfg_sel = 2'(sel); cfg_data = 16'(data);
      cfg_commit = commit;
      @(negedge clock);
      cfg_we = 1'b0; cfg_commit = 1'b0;
   endtask

   task automatic send(input int v, input longint ev, input bit expect_out, input bit commit);
      int w;
      w = 0;
      while (!in_ready && w < 40) begin
         @(negedge clock);
         w++;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL send_timeout: in_ready=%0d after %0d cycles, required 1", in_ready, w);
      end else begin
         if (expect_out) q.push_back('{51'(ev), cyc + 8});
         in_valid = 1'b1; in = 34'(v); cfg_commit = commit;
         @(negedge clock);
         in_valid = 1'b0; cfg_commit = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while (!in_ready && w < 40) begin
         @(negedge clock);
         w++;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL idle_timeout: in_ready=%0d, required 1", in_ready);
      end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in = '0; cfg_we = 1'b0; cfg_addr = '0;
      cfg_sel = '0; cfg_data = '0; cfg_commit = 1'b0;
      @(negedge clock);
      do_reset();

      // pass-through with busy window
      cfg_write(0, 0, 1024, 1);
      send(100, 100, 1, 0);
      for (int i = 0; i < 8; i++) begin
         check("in_ready_while_busy", longint'(in_ready), 0);
         check("busy_while_busy", longint'(busy), 1);
         @(negedge clock);
      end
      check("in_ready_after_done", longint'(in_ready), 1);

      // shadow write without commit, commit coincident with sample, write+commit together
      cfg_write(0, 0, 2048, 0);
      send(10, 10, 1, 0);
      send(10, 20, 1, 1);
      cfg_write(0, 0, 4096, 1);
      send(10, 40, 1, 0);
      wait_idle();

      // first-order recursion
      do_reset();
      cfg_write(0, 0, 1024, 0);
      cfg_write(0, 2, -512, 1);
      send(1024, 1024, 1, 0);
      send(0, 512, 1, 0);
      send(0, 256, 1, 0);
      wait_idle();

      // several sections, x_prev and y2 terms, out-of-range address dropped
      do_reset();
      cfg_write(0, 0, 1024, 0);
      cfg_write(3, 0, 1024, 0);
      cfg_write(3, 3, -1024, 0);
      cfg_write(6, 0, 2048, 0);
      cfg_write(6, 1, 1024, 0);
      cfg_write(7, 0, 1024, 1);
      send(5, 20, 1, 0);
      send(7, 33, 1, 0);
      send(0, 12, 1, 0);
      wait_idle();

      // floor rounding and in_valid ignored while busy
      do_reset();
      cfg_write(0, 0, 512, 1);
      send(-3, -2, 1, 0);
      repeat (2) @(negedge clock);
      in_valid = 1'b1; in = 34'(1000);
      @(negedge clock);
      in_valid = 1'b0;
      wait_idle();
      repeat (10) @(negedge clock);

      // reset mid-RUN aborts and clears section state
      do_reset();
      cfg_write(0, 0, 1024, 1);
      send(100, 100, 1, 0);
      send(100, 0, 0, 0);
      repeat (2) @(negedge clock);
      do_reset();
      repeat (10) @(negedge clock);
      cfg_write(0, 0, 1024, 0);
      cfg_write(0, 2, -512, 1);
      send(100, 100, 1, 0);
      wait_idle();

      for (int w = 0; w < 400 && !done8; w++) @(negedge clock);
      check("dut8_done", longint'(done8), 1);
      check("queue_drained", longint'(q.size()), 0);
      check("queue8_drained", longint'(q8.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      logic signed [24:0] exp8 [5];
      int w;
      bit sat_req;
      exp8[0] = 25'sd4063;
      exp8[1] = 25'sd130016;
      exp8[2] = 25'sd4160512;
`ifdef SHAPER_TDM_SAT_EN
      exp8[3] = 25'sd16777215;
      exp8[4] = 25'sd16777215;
      sat_req = 1'b1;
`else
      exp8[3] = -25'sd1081344;
      exp8[4] = -25'sd1048576;
      sat_req = 1'b0;
`endif
      reset8 = 1'b1; in_valid8 = 1'b0; in8 = '0; cfg_we8 = 1'b0; cfg_addr8 = '0;
      cfg_sel8 = '0; cfg_data8 = '0; cfg_commit8 = 1'b0;
      repeat (3) @(negedge clock);
      reset8 = 1'b0;
      cfg_we8 = 1'b1; cfg_addr8 = 3'd0; cfg_sel8 = 2'd0; cfg_data8 = 16'sd32767;
      @(negedge clock);
      cfg_sel8 = 2'd2; cfg_data8 = -16'sd32768; cfg_commit8 = 1'b1;
      @(negedge clock);
      cfg_we8 = 1'b0; cfg_commit8 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         w = 0;
         while (!in_ready8 && w < 40) begin
            @(negedge clock);
            w++;
         end
         q8.push_back(exp8[i]);
         in_valid8 = 1'b1; in8 = (i == 0) ? 8'sd127 : 8'sd0;
         @(negedge clock);
         in_valid8 = 1'b0;
      end
      w = 0;
      while (!in_ready8 && w < 40) begin
         @(negedge clock);
         w++;
      end
      check("sat_flag8", longint'(sat_flag8), longint'(sat_req));
      done8 = 1'b1;
   end

endmodule

// File: doc/shaper_tdm_scheduler.md
# shaper_tdm_scheduler

Time-multiplexed scheduler for the shaper filter bank. The bank is a parallel set of first- and second-order IIR sections whose outputs are summed. This block replaces dedicated per-section hardware with one shared MAC. Once per accepted input sample it sequences all sections through that MAC, holds each section's recursive state, and accumulates the bank output. Coefficients are runtime-loadable from the HPS side through a shadow bank with atomic commit.

## Interface
- BITS_IN, 34, input sample width (signed)
- NUM_SEC, 7, number of sections
- COEF_W, 16, signed coefficient width
- G_SAIDA_LOG, 10, right-shift applied to each section's MAC sum
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input sample valid
- in  in  BITS_IN  signed input sample
- in_ready  out  1  block can accept a sample
- cfg_we  in  1  shadow coefficient write strobe
- cfg_addr  in  $clog2(NUM_SEC)  section index
- cfg_sel  in  2  coefficient select: 0=b0, 1=b1, 2=a1, 3=a2
- cfg_data  in  COEF_W  signed coefficient
- cfg_commit  in  1  request shadow→active copy
- out_valid  out  1  one-cycle strobe, bank output valid
- out  out  BITS_IN+17  signed bank output (sum of all sections)
- busy  out  1  state ≠ IDLE
- sat_flag  out  1  sticky section saturation (see Configuration)

## Operation
- States: IDLE → RUN (sec = 0..NUM_SEC-1, one section per cycle) → DONE → IDLE.
- in_ready = (state==IDLE) & ~reset.
- Transfer occurs when in_valid & in_ready. The sample is latched as x, and sec clears to 0.
- in_valid while not ready is ignored; no queueing.
- Section k, per cycle in RUN:
  - s = b0·x + b1·x_prev − a1·y1[k] − a2·y2[k], computed at full width SW+COEF_W+2, with SW = BITS_IN+17.
  - y = s >>> G_SAIDA_LOG (arithmetic shift, floor), reduced to SW bits.
  - Update: y2[k] ← y1[k], y1[k] ← y; acc ← acc + y, modulo 2^SW.
- First-order sections are simply loaded with b1 = a2 = 0.
- x_prev is shared by all sections. It is updated to x on the DONE cycle.
- DONE: out ← acc, out_valid = 1 for exactly that cycle, acc cleared.
- cfg_we writes shadow[cfg_addr][cfg_sel] in any state. Writes with cfg_addr ≥ NUM_SEC are dropped.
- cfg_commit sets commit_pending in any state.
- Commit timing:
  - commit_pending is applied only in IDLE. The copy is atomic: all 4·NUM_SEC coefficients in one cycle, then commit_pending clears.
  - If commit_pending (or cfg_commit itself) coincides with an accepted sample, the copy happens first and that sample uses the new coefficients.
  - Committing never alters y1, y2 or x_prev.
- cfg_we and cfg_commit in the same cycle: the write lands in the shadow bank and is included in the commit.
- Reset values: state IDLE; in_ready 0 while reset high; out_valid 0; out 0; busy 0; sat_flag 0; active and shadow coefficients 0; all y1/y2, x_prev, acc and commit_pending 0.
- Reset during RUN or DONE aborts the sample. No out_valid is produced.

## Timing
- Sample accepted at cycle T. Sections are evaluated in cycles T+1..T+NUM_SEC.
- out_valid at T+NUM_SEC+1, i.e. T+8 at default.
- in_ready is high again at T+NUM_SEC+2. Maximum throughput is one sample per NUM_SEC+2 cycles.
- MAC is single-cycle combinational between the state/coefficient registers and the y1/acc registers. No extra pipeline stages.

## Configuration
- Macro SHAPER_TDM_SAT_EN.
- Defined: each section's shifted result saturates to [−2^(SW−1), 2^(SW−1)−1] before it is stored and accumulated. Any clipping sets sat_flag, which stays set until reset.
- Undefined: the result wraps modulo 2^SW, and sat_flag is tied to 0.
- The bank-level sum wraps in both builds.

## Structure
- Package shaper_tdm_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - coefficient-select localparams COEF_B0/B1/A1/A2
  - SW and MAC-width constant functions
- Sub-module iir_sec_mac: combinational shared MAC, arithmetic shift, and the optional saturation with its clip indicator.
- The scheduler owns the FSM, the coefficient banks, and the per-section state arrays.

## Test plan
- Pass-through: section 0 committed with b0=1024, all others 0; in=100 → out_valid 8 cycles later with out=100; in_ready low during those cycles.
- Recursion: section 0 with b0=1024, a1=−512; input sequence 1024, 0, 0 → outputs 1024, 512, 256.
- Atomic commit: from the pass-through setup, write b0=2048 without commit; in=10 → out=10. Pulse cfg_commit together with in_valid (in=10) → out=20.
- Floor rounding: b0=512, in=−3 → out=−2. in_valid pulsed while busy is ignored; exactly one out_valid results.
- Saturation, BITS_IN=8 build:
  - Setup: b0=32767, a1=−32768, in=127, then zeros.
  - With SHAPER_TDM_SAT_EN: out clamps at 16777215 within 5 samples and sat_flag stays 1.
  - Without the macro: out wraps and sat_flag stays 0.
- Reset mid-RUN: assert reset 3 cycles after acceptance → no out_valid; y states are zero. A subsequent in=100 reproduces the fresh pass-through result of 100.
